flow_stack: RTL and testbench

Parametrised control-flow state unit for the pipelined processor: holds the call/return address stack and the per-lane enable-mask stack that gate register and memory writeback. Generalises the fixed 4-entry × 16-bit call stack and 32-deep × 1-lane enable stack to configurable address width, depths and lane count. Adds occupancy reporting and overflow/underflow detection. The decode stage issues at most one stack operation per cycle; fetch reads `ret_addr`; writeback reads `en_mask`.

---
 rtl/flow_stack_pkg.sv | 41 ++++
 rtl/flow_stack_if.sv | 39 +++
 rtl/flow_stack_lifo_core.sv | 62 ++++++
 rtl/flow_stack.sv | 120 ++++++++++++
 tb/tb_flow_stack.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/flow_stack_pkg.sv
// flow_stack_pkg: op encoding shared by decode and flow_stack, plus the
// per-stack command bundle that flow_stack derives from a decoded op.
package flow_stack_pkg;

  localparam int FS_OP_W = 3;

  localparam logic [FS_OP_W-1:0] FS_OP_NONE   = 3'd0;
  localparam logic [FS_OP_W-1:0] FS_OP_CALL   = 3'd1;
  localparam logic [FS_OP_W-1:0] FS_OP_RET    = 3'd2;
  localparam logic [FS_OP_W-1:0] FS_OP_PUSHEN = 3'd3;
  localparam logic [FS_OP_W-1:0] FS_OP_POPEN  = 3'd4;
  localparam logic [FS_OP_W-1:0] FS_OP_ALLEN  = 3'd5;

  // One command per stack per cycle; at most one field is set.
  typedef struct packed {
    logic push;
    logic pop;
    logic repl;
  } fs_stack_cmd_t;

  // Split a qualified op into call-stack and enable-stack commands.
  // Codes 6 and 7 fall through to "no command".
  function automatic void fs_decode(input  logic               valid,
                                    input  logic [FS_OP_W-1:0] op,
                                    output fs_stack_cmd_t      call_cmd,
                                    output fs_stack_cmd_t      en_cmd);
    call_cmd = '0;
    en_cmd   = '0;
    if (valid) begin
      case (op)
        FS_OP_CALL:   call_cmd.push = 1'b1;
        FS_OP_RET:    call_cmd.pop  = 1'b1;
        FS_OP_PUSHEN: en_cmd.push   = 1'b1;
        FS_OP_POPEN:  en_cmd.pop    = 1'b1;
        FS_OP_ALLEN:  en_cmd.repl   = 1'b1;
        default: ;
      endcase
    end
  endfunction

endpackage

// File: rtl/flow_stack_if.sv
// flow_stack_if: decode-side op bus plus the status seen by fetch/writeback.
//
// Handshake: op_valid qualifies op/call_pc/cond_mask for exactly the cycle it
// is high. There is no ready: the unit accepts one op every cycle, so an op
// is consumed on the rising edge where op_valid=1. err_clr is a level input
// sampled every edge, independent of op_valid.
interface flow_stack_if #(
  parameter int ADDR_W     = 16,
  parameter int CALL_DEPTH = 4,
  parameter int LANES      = 1
);
  logic                                op_valid;
  logic [flow_stack_pkg::FS_OP_W-1:0]  op;
  logic [ADDR_W-1:0]                   call_pc;
  logic [LANES-1:0]                    cond_mask;
  logic                                err_clr;

  logic [ADDR_W-1:0]                   ret_addr;
  logic                                ret_valid;
  logic [$clog2(CALL_DEPTH+1)-1:0]     call_depth;
  logic [LANES-1:0]                    en_mask;
  logic                                any_en;
  logic                                err_overflow;
  logic                                err_underflow;

  // Decode stage drives ops and observes status.
  modport master (
    output op_valid, op, call_pc, cond_mask, err_clr,
    input  ret_addr, ret_valid, call_depth, en_mask, any_en,
           err_overflow, err_underflow
  );

  // flow_stack consumes ops and drives status.
  modport slave (
    input  op_valid, op, call_pc, cond_mask, err_clr,
    output ret_addr, ret_valid, call_depth, en_mask, any_en,
           err_overflow, err_underflow
  );
endinterface

// File: rtl/flow_stack_lifo_core.sv
// lifo_core: push / pop / replace-top stack. A push into a full stack drops
// the oldest entry; a pop from an empty stack is a no-op. The top reads
// RESET_VAL whenever the stack is empty. overflow/underflow are same-cycle
// event strobes for the operation being presented.
module lifo_core #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = $clog2(DEPTH + 1),
  localparam int              IW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             repl,
  input  logic [WIDTH-1:0] push_data,
  input  logic [WIDTH-1:0] repl_data,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] top,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt;
  logic             full;
  logic             empty;
  logic [IW-1:0]    top_idx;
  logic [IW-1:0]    wr_idx;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign top_idx = IW'(cnt - CW'(1));
  assign wr_idx  = IW'(cnt);

  assign count     = cnt;
  assign top       = empty ? RESET_VAL : mem[top_idx];
  assign overflow  = push & full;
  assign underflow = pop & ~push & empty;

  // Storage and occupancy: push wins over pop, pop over replace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
    end else if (push) begin
      if (full) begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
        mem[DEPTH-1] <= push_data;
      end else begin
        mem[wr_idx] <= push_data;
        cnt         <= cnt + CW'(1);
      end
    end else if (pop) begin
      if (!empty) cnt <= cnt - CW'(1);
    end else if (repl && !empty) begin
      mem[top_idx] <= repl_data;
    end
  end

endmodule

// File: rtl/flow_stack.sv
// flow_stack: call/return address stack and per-lane enable-mask stack.
// Two independent lifo_core instances; every status output comes straight
// from registered state, so ret_addr already shows the entry a RET pops.
// Optional build macro: FLOW_STACK_ERR_EN adds sticky overflow/underflow
// flags cleared by err_clr; without it the flags read 0.
module flow_stack
  import flow_stack_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int CALL_DEPTH = 4,
  parameter int EN_DEPTH   = 32,
  parameter int LANES      = 1
) (
  input  logic         clk,
  input  logic         reset,
  flow_stack_if.slave  bus
);

  localparam int CCW = $clog2(CALL_DEPTH + 1);
  localparam int ECW = $clog2(EN_DEPTH + 1);

  fs_stack_cmd_t     call_cmd;
  fs_stack_cmd_t     en_cmd;
  logic [ADDR_W-1:0] ret_next;
  logic [CCW-1:0]    call_cnt;
  logic [ADDR_W-1:0] call_top;
  logic              call_ovf;
  logic              call_unf;
  logic [LANES-1:0]  en_push_val;
  logic [ECW-1:0]    en_cnt;
  logic [LANES-1:0]  en_top;
  logic              en_ovf;
  logic              en_unf;

  // Route the decoded op to exactly one of the two stacks.
  always_comb begin
    call_cmd = '0;
    en_cmd   = '0;
    fs_decode(bus.op_valid, bus.op, call_cmd, en_cmd);
  end

  // Return target wraps modulo 2^ADDR_W.
  assign ret_next    = bus.call_pc + ADDR_W'(1);
  // A nested condition can only narrow the currently enabled lanes.
  assign en_push_val = en_top & bus.cond_mask;

  lifo_core #(
    .WIDTH     (ADDR_W),
    .DEPTH     (CALL_DEPTH),
    .RESET_VAL ('0)
  ) u_call (
    .clk       (clk),
    .rst_n     (reset),
    .push      (call_cmd.push),
    .pop       (call_cmd.pop),
    .repl      (call_cmd.repl),
    .push_data (ret_next),
    .repl_data (ret_next),
    .count     (call_cnt),
    .top       (call_top),
    .overflow  (call_ovf),
    .underflow (call_unf)
  );

  lifo_core #(
    .WIDTH     (LANES),
    .DEPTH     (EN_DEPTH),
    .RESET_VAL ({LANES{1'b1}})
  ) u_en (
    .clk       (clk),
    .rst_n     (reset),
    .push      (en_cmd.push),
    .pop       (en_cmd.pop),
    .repl      (en_cmd.repl),
    .push_data (en_push_val),
    .repl_data ({LANES{1'b1}}),
    .count     (en_cnt),
    .top       (en_top),
    .overflow  (en_ovf),
    .underflow (en_unf)
  );

  assign bus.ret_addr   = call_top;
  assign bus.ret_valid  = (call_cnt != '0);
  assign bus.call_depth = call_cnt;
  assign bus.en_mask    = en_top;
  assign bus.any_en     = |en_top;

  // Enable-stack occupancy is internal only.
  logic unused_en_cnt;
  assign unused_en_cnt = &{1'b0, en_cnt};

`ifdef FLOW_STACK_ERR_EN
  logic ovf_q;
  logic unf_q;

  // Sticky error flags; a new event in the same cycle beats err_clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (call_ovf || en_ovf)   ovf_q <= 1'b1;
      else if (bus.err_clr)     ovf_q <= 1'b0;
      if (call_unf || en_unf)   unf_q <= 1'b1;
      else if (bus.err_clr)     unf_q <= 1'b0;
    end
  end

  assign bus.err_overflow  = ovf_q;
  assign bus.err_underflow = unf_q;
`else
  // Flags absent in this build; saturation/discard behaviour is unchanged.
  logic unused_err;
  assign unused_err        = &{1'b0, bus.err_clr, call_ovf, call_unf, en_ovf, en_unf};
  assign bus.err_overflow  = 1'b0;
  assign bus.err_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_flow_stack.sv
// tb_flow_stack: scoreboard bench for flow_stack (LANES=4, other defaults).
module tb_flow_stack;
  import flow_stack_pkg::*;

  localparam int ADDR_W     = 16;
  localparam int CALL_DEPTH = 4;
  localparam int EN_DEPTH   = 32;
  localparam int LANES      = 4;
  localparam int DW         = $clog2(CALL_DEPTH + 1);
  localparam int W          = ADDR_W + 1 + DW + LANES + 3;
`ifdef FLOW_STACK_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  flow_stack_if #(.ADDR_W(ADDR_W), .CALL_DEPTH(CALL_DEPTH), .LANES(LANES)) bus ();

  flow_stack #(
    .ADDR_W(ADDR_W), .CALL_DEPTH(CALL_DEPTH), .EN_DEPTH(EN_DEPTH), .LANES(LANES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0]      exp_q[$];
  logic [ADDR_W-1:0] m_call[$];
  logic [LANES-1:0]  m_en[$];
  logic              m_ovf;
  logic              m_unf;
  int                vec_cnt = 0;
  int                err_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] m_ret_top();
    return (m_call.size() != 0) ? m_call[$] : '0;
  endfunction

  function automatic logic [LANES-1:0] m_en_top();
    return (m_en.size() != 0) ? m_en[$] : '1;
  endfunction

  function automatic logic [W-1:0] model_snap();
    logic [LANES-1:0] en;
    en = m_en_top();
    return {m_ret_top(), logic'(m_call.size() != 0), DW'(m_call.size()),
            en, |en, m_ovf, m_unf};
  endfunction

  task automatic model_reset();
    m_call.delete();
    m_en.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [FS_OP_W-1:0] o,
                            input logic [ADDR_W-1:0] pc, input logic [LANES-1:0] m,
                            input logic clr);
    logic ovf_e, unf_e;
    logic [LANES-1:0] t;
    ovf_e = 1'b0;
    unf_e = 1'b0;
    if (v) begin
      case (o)
        FS_OP_CALL: begin
          if (m_call.size() == CALL_DEPTH) begin void'(m_call.pop_front()); ovf_e = 1'b1; end
          m_call.push_back(ADDR_W'(pc + 1));
        end
        FS_OP_RET: begin
          if (m_call.size() == 0) unf_e = 1'b1;
          else void'(m_call.pop_back());
        end
        FS_OP_PUSHEN: begin
          t = m_en_top();
          if (m_en.size() == EN_DEPTH) begin void'(m_en.pop_front()); ovf_e = 1'b1; end
          m_en.push_back(t & m);
        end
        FS_OP_POPEN: begin
          if (m_en.size() == 0) unf_e = 1'b1;
          else void'(m_en.pop_back());
        end
        FS_OP_ALLEN: begin
          if (m_en.size() != 0) m_en[m_en.size()-1] = '1;
        end
        default: ;
      endcase
    end
    if (ERR_EN) begin
      m_ovf = ovf_e ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_unf = unf_e ? 1'b1 : (clr ? 1'b0 : m_unf);
    end
  endtask

  task automatic compare_snap(input string tag);
    logic [W-1:0] e, g;
    logic [ADDR_W-1:0] e_ra, g_ra;
    logic e_rv, g_rv, e_any, g_any, e_o, g_o, e_u, g_u;
    logic [DW-1:0] e_d, g_d;
    logic [LANES-1:0] e_en, g_en;
    if (exp_q.size() == 0) begin
      check_val({tag, ".exp_q_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    g = {bus.ret_addr, bus.ret_valid, bus.call_depth, bus.en_mask, bus.any_en,
         bus.err_overflow, bus.err_underflow};
    {e_ra, e_rv, e_d, e_en, e_any, e_o, e_u} = e;
    {g_ra, g_rv, g_d, g_en, g_any, g_o, g_u} = g;
    check_val({tag, ".ret_addr"},   32'(g_ra),  32'(e_ra));
    check_val({tag, ".ret_valid"},  32'(g_rv),  32'(e_rv));
    check_val({tag, ".call_depth"}, 32'(g_d),   32'(e_d));
    check_val({tag, ".en_mask"},    32'(g_en),  32'(e_en));
    check_val({tag, ".any_en"},     32'(g_any), 32'(e_any));
    check_val({tag, ".err_ovf"},    32'(g_o),   32'(e_o));
    check_val({tag, ".err_unf"},    32'(g_u),   32'(e_u));
  endtask

  // ---------------- driver tasks ----------------
  // pre_exp >= 0 additionally pins the same-cycle ret_addr to a constant.
  task automatic apply(input logic v, input logic [FS_OP_W-1:0] o,
                       input logic [ADDR_W-1:0] pc, input logic [LANES-1:0] m,
                       input logic clr, input string tag, input int pre_exp = -1);
    @(negedge clk);
    bus.op_valid  = v;
    bus.op        = o;
    bus.call_pc   = pc;
    bus.cond_mask = m;
    bus.err_clr   = clr;
    #1;
    if (v && o == FS_OP_RET) begin
      check_val({tag, ".ret_pre"}, 32'(bus.ret_addr), 32'(m_ret_top()));
      if (pre_exp >= 0) check_val({tag, ".ret_pre_k"}, 32'(bus.ret_addr), pre_exp);
    end
    model_step(v, o, pc, m, clr);
    exp_q.push_back(model_snap());
    @(posedge clk);
    #1;
    compare_snap(tag);
    bus.op_valid = 1'b0;
    bus.err_clr  = 1'b0;
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    bus.op_valid  = 1'b0;
    bus.op        = FS_OP_NONE;
    bus.call_pc   = '0;
    bus.cond_mask = '0;
    bus.err_clr   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".ret_addr"},   32'(bus.ret_addr),      32'h0);
    check_val({tag, ".ret_valid"},  32'(bus.ret_valid),     32'h0);
    check_val({tag, ".call_depth"}, 32'(bus.call_depth),    32'h0);
    check_val({tag, ".en_mask"},    32'(bus.en_mask),       32'hF);
    check_val({tag, ".any_en"},     32'(bus.any_en),        32'h1);
    check_val({tag, ".err_ovf"},    32'(bus.err_overflow),  32'h0);
    check_val({tag, ".err_unf"},    32'(bus.err_underflow), 32'h0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    #1;
    check_reset_outputs("rst");

    // Three nested calls, then unwind.
    apply(1, FS_OP_CALL, 16'h0010, '0, 0, "call1");
    apply(1, FS_OP_CALL, 16'h0020, '0, 0, "call2");
    apply(1, FS_OP_CALL, 16'h0030, '0, 0, "call3");
    check_val("nest.depth", 32'(bus.call_depth), 32'd3);
    check_val("nest.top",   32'(bus.ret_addr),   32'h31);
    apply(1, FS_OP_RET, '0, '0, 0, "ret1", 'h31);
    apply(1, FS_OP_RET, '0, '0, 0, "ret2", 'h21);
    apply(1, FS_OP_RET, '0, '0, 0, "ret3", 'h11);
    check_val("nest.ret_valid", 32'(bus.ret_valid), 32'd0);

    // Call-stack overflow discards the oldest return address.
    for (int i = 1; i <= 5; i++) apply(1, FS_OP_CALL, ADDR_W'(i), '0, 0, "ovf_call");
    for (int i = 0; i < 4; i++) apply(1, FS_OP_RET, '0, '0, 0, "ovf_ret", 6 - i);
    check_val("ovf.flag",  32'(bus.err_overflow), 32'(ERR_EN));
    check_val("ovf.depth", 32'(bus.call_depth),   32'd0);
    apply(1, FS_OP_NONE, '0, '0, 1, "clr1");

    // RET on empty stack.
    apply(1, FS_OP_RET, '0, '0, 0, "ret_empty", 0);
    check_val("unf.flag", 32'(bus.err_underflow), 32'(ERR_EN));
    apply(0, FS_OP_NONE, '0, '0, 1, "clr2");
    check_val("unf.clr", 32'(bus.err_underflow), 32'd0);

    // Enable-mask nesting.
    apply(1, FS_OP_PUSHEN, '0, 4'b1010, 0, "pushen1");
    check_val("en.push1", 32'(bus.en_mask), 32'b1010);
    apply(1, FS_OP_PUSHEN, '0, 4'b0110, 0, "pushen2");
    check_val("en.push2", 32'(bus.en_mask), 32'b0010);
    apply(1, FS_OP_POPEN, '0, '0, 0, "popen1");
    check_val("en.pop1", 32'(bus.en_mask), 32'b1010);
    apply(1, FS_OP_ALLEN, '0, '0, 0, "allen");
    check_val("en.allen", 32'(bus.en_mask), 32'b1111);
    apply(1, FS_OP_POPEN, '0, '0, 0, "popen2");
    check_val("en.depth_kept", 32'(bus.err_underflow), 32'd0);
    apply(1, FS_OP_POPEN, '0, '0, 0, "popen_base");
    check_val("en.base_mask", 32'(bus.en_mask),       32'hF);
    check_val("en.base_any",  32'(bus.any_en),        32'd1);
    check_val("en.base_unf",  32'(bus.err_underflow), 32'(ERR_EN));

    // New error wins over a simultaneous clear.
    apply(1, FS_OP_RET, '0, '0, 1, "clr_vs_err", 0);
    check_val("clr_vs_err.flag", 32'(bus.err_underflow), 32'(ERR_EN));

    // Fill the enable stack past its depth, then drain below the base.
    for (int i = 0; i < EN_DEPTH + 2; i++)
      apply(1, FS_OP_PUSHEN, '0, LANES'($urandom_range(0, 15)) | 4'b1000, 0, "en_fill");
    for (int i = 0; i < EN_DEPTH + 2; i++)
      apply(1, FS_OP_POPEN, '0, '0, (i == 0), "en_drain");

    // Random mix, including op codes 6-7 and idle cycles.
    for (int i = 0; i < 300; i++)
      apply(logic'($urandom_range(0, 3) != 0), FS_OP_W'($urandom_range(0, 7)),
            ADDR_W'($urandom_range(0, 16'hFFFF)), LANES'($urandom_range(0, 15)),
            logic'($urandom_range(0, 7) == 0), "rand");

    // Asynchronous reset between edges.
    do_reset();
    apply(1, FS_OP_CALL,   16'h0100, '0,    0, "ar_call1");
    apply(1, FS_OP_CALL,   16'h0200, '0,    0, "ar_call2");
    apply(1, FS_OP_PUSHEN, '0,       4'b0000, 0, "ar_pushen");
    check_val("ar.any_en_pre", 32'(bus.any_en), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("ar");
    bus.op_valid = 1'b1;
    bus.op       = FS_OP_CALL;
    bus.call_pc  = 16'h0400;
    @(posedge clk);
    #1;
    check_val("ar.op_ignored", 32'(bus.call_depth), 32'd0);
    @(negedge clk);
    bus.op_valid = 1'b0;
    reset        = 1'b1;
    apply(1, FS_OP_CALL, 16'h0500, '0, 0, "ar_after", -1);
    apply(1, FS_OP_RET,  '0,       '0, 0, "ar_after_ret", 'h501);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
